// File: rtl/dsp_decode_stage_pkg.sv
// Shared opcode, field and control-code definitions for the DSP decode stage.
package dsp_decode_stage_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int OPC_W    = 6;
  localparam int S1_LSB   = 21;
  localparam int S2_LSB   = 16;
  localparam int DEST_LSB = 11;

  localparam logic [5:0] OP_ADD    = 6'h00;
  localparam logic [5:0] OP_ADD_I  = 6'h01;
  localparam logic [5:0] OP_IADD   = 6'h02;
  localparam logic [5:0] OP_IADD_I = 6'h03;
  localparam logic [5:0] OP_SUB    = 6'h04;
  localparam logic [5:0] OP_SUB_I  = 6'h05;
  localparam logic [5:0] OP_ISUB   = 6'h06;
  localparam logic [5:0] OP_ISUB_I = 6'h07;
  localparam logic [5:0] OP_MUL    = 6'h08;
  localparam logic [5:0] OP_MUL_I  = 6'h09;
  localparam logic [5:0] OP_IMUL   = 6'h0A;
  localparam logic [5:0] OP_IMUL_I = 6'h0B;
  localparam logic [5:0] OP_SQR    = 6'h0C;
  localparam logic [5:0] OP_MAC    = 6'h0D;
  localparam logic [5:0] OP_AND    = 6'h10;
  localparam logic [5:0] OP_AND_I  = 6'h11;
  localparam logic [5:0] OP_OR     = 6'h12;
  localparam logic [5:0] OP_OR_I   = 6'h13;
  localparam logic [5:0] OP_XOR    = 6'h14;
  localparam logic [5:0] OP_XOR_I  = 6'h15;
  localparam logic [5:0] OP_SHLA   = 6'h16;
  localparam logic [5:0] OP_SHRA   = 6'h17;
  localparam logic [5:0] OP_SHLL   = 6'h18;
  localparam logic [5:0] OP_SHRL   = 6'h19;
  localparam logic [5:0] OP_ROL    = 6'h1A;
  localparam logic [5:0] OP_ROR    = 6'h1B;
  localparam logic [5:0] OP_JMP    = 6'h20;
  localparam logic [5:0] OP_BEZ    = 6'h21;
  localparam logic [5:0] OP_BNEZ   = 6'h22;
  localparam logic [5:0] OP_BEQ    = 6'h23;
  localparam logic [5:0] OP_PUSH   = 6'h30;
  localparam logic [5:0] OP_POP    = 6'h31;
  localparam logic [5:0] OP_LD     = 6'h32;
  localparam logic [5:0] OP_ST     = 6'h33;
  localparam logic [5:0] OP_LD_IMM = 6'h34;

  typedef enum logic [7:0] {
    ALU_NOP    = 8'h00,
    ALU_ADD    = 8'h01, ALU_ADD_I  = 8'h02, ALU_IADD   = 8'h03, ALU_IADD_I = 8'h04,
    ALU_SUB    = 8'h05, ALU_SUB_I  = 8'h06, ALU_ISUB   = 8'h07, ALU_ISUB_I = 8'h08,
    ALU_MUL    = 8'h09, ALU_MUL_I  = 8'h0A, ALU_IMUL   = 8'h0B, ALU_IMUL_I = 8'h0C,
    ALU_SQR    = 8'h0D, ALU_MAC    = 8'h0E,
    ALU_AND    = 8'h10, ALU_AND_I  = 8'h11, ALU_OR     = 8'h12, ALU_OR_I   = 8'h13,
    ALU_XOR    = 8'h14, ALU_XOR_I  = 8'h15, ALU_SHLA   = 8'h16, ALU_SHRA   = 8'h17,
    ALU_SHLL   = 8'h18, ALU_SHRL   = 8'h19, ALU_ROL    = 8'h1A, ALU_ROR    = 8'h1B
  } alu_mode_e;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0, MEM_PUSH = 3'd1, MEM_POP = 3'd2,
    MEM_LD   = 3'd3, MEM_ST   = 3'd4, MEM_LD_IMM = 3'd5
  } mem_mode_e;

  typedef enum logic [2:0] {
    FLOW_NONE = 3'd0, FLOW_JMP = 3'd1, FLOW_BEZ = 3'd2,
    FLOW_BNEZ = 3'd3, FLOW_BEQ = 3'd4
  } flow_mode_e;

endpackage

// File: rtl/dsp_scoreboard.sv
// Register busy-bit scoreboard: one set port (issue), one clear port (writeback),
// two combinational lookup ports plus the full busy vector.
module dsp_scoreboard #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_en,
  input  logic [REG_ADDR_W-1:0]   set_reg,
  input  logic                    clr_en,
  input  logic [REG_ADDR_W-1:0]   clr_reg,
  input  logic [REG_ADDR_W-1:0]   rd_a_reg,
  output logic                    rd_a_busy,
  input  logic [REG_ADDR_W-1:0]   rd_b_reg,
  output logic                    rd_b_busy,
  output logic [2**REG_ADDR_W-1:0] busy
);

  localparam int NUM_REGS = 2**REG_ADDR_W;

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Set is applied after clear so an issue wins over a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_reg] = 1'b0;
    if (set_en) busy_d[set_reg] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign rd_a_busy = busy_q[rd_a_reg];
  assign rd_b_busy = busy_q[rd_b_reg];
  assign busy      = busy_q;

endmodule

// File: rtl/dsp_decode_stage.sv
// Registered, handshaked decode stage with RAW/WAW scoreboard stall.
// Optional DSP_DECODE_TRAP_EN adds a sticky trap output that halts issue on illegal words.
module dsp_decode_stage import dsp_decode_stage_pkg::*; #(
  parameter int INST_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_ADDR_W = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_W-1:0]     in_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_alu_mode,
  output logic                  out_r_w,
  output logic [2:0]            out_mem_mode,
  output logic [2:0]            out_flow_mode,
  output logic [REG_ADDR_W-1:0] out_reg_s1,
  output logic [REG_ADDR_W-1:0] out_reg_s2,
  output logic [REG_ADDR_W-1:0] out_reg_dest,
  output logic [MEM_ADDR_W-1:0] out_address,
  output logic                  out_illegal,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  output logic [CNT_W-1:0]      cnt_issued,
  output logic [CNT_W-1:0]      cnt_illegal
`ifdef DSP_DECODE_TRAP_EN
  ,
  output logic                  trap
`endif
);

  localparam int NUM_REGS = 2**REG_ADDR_W;

  logic [OPC_W-1:0]      op;
  alu_mode_e             alu;
  mem_mode_e             mem;
  flow_mode_e            flow;
  logic                  imm, is_alu, illegal, use_s1, use_s2, r_w, wr, rtype;
  logic [REG_ADDR_W-1:0] s1, s2, dest;

  always_comb begin
    op   = in_inst[INST_W-1 -: OPC_W];
    alu  = ALU_NOP;
    mem  = MEM_NONE;
    flow = FLOW_NONE;
    imm  = FALSE;
    case (op)
      OP_ADD:    alu = ALU_ADD;
      OP_ADD_I:  begin alu = ALU_ADD_I;  imm = TRUE; end
      OP_IADD:   alu = ALU_IADD;
      OP_IADD_I: begin alu = ALU_IADD_I; imm = TRUE; end
      OP_SUB:    alu = ALU_SUB;
      OP_SUB_I:  begin alu = ALU_SUB_I;  imm = TRUE; end
      OP_ISUB:   alu = ALU_ISUB;
      OP_ISUB_I: begin alu = ALU_ISUB_I; imm = TRUE; end
      OP_MUL:    alu = ALU_MUL;
      OP_MUL_I:  begin alu = ALU_MUL_I;  imm = TRUE; end
      OP_IMUL:   alu = ALU_IMUL;
      OP_IMUL_I: begin alu = ALU_IMUL_I; imm = TRUE; end
      OP_SQR:    alu = ALU_SQR;
      OP_MAC:    alu = ALU_MAC;
      OP_AND:    alu = ALU_AND;
      OP_AND_I:  begin alu = ALU_AND_I;  imm = TRUE; end
      OP_OR:     alu = ALU_OR;
      OP_OR_I:   begin alu = ALU_OR_I;   imm = TRUE; end
      OP_XOR:    alu = ALU_XOR;
      OP_XOR_I:  begin alu = ALU_XOR_I;  imm = TRUE; end
      OP_SHLA:   alu = ALU_SHLA;
      OP_SHRA:   alu = ALU_SHRA;
      OP_SHLL:   alu = ALU_SHLL;
      OP_SHRL:   alu = ALU_SHRL;
      OP_ROL:    alu = ALU_ROL;
      OP_ROR:    alu = ALU_ROR;
      OP_JMP:    flow = FLOW_JMP;
      OP_BEZ:    flow = FLOW_BEZ;
      OP_BNEZ:   flow = FLOW_BNEZ;
      OP_BEQ:    flow = FLOW_BEQ;
      OP_PUSH:   mem = MEM_PUSH;
      OP_POP:    mem = MEM_POP;
      OP_LD:     mem = MEM_LD;
      OP_ST:     mem = MEM_ST;
      OP_LD_IMM: mem = MEM_LD_IMM;
      default:   ;
    endcase

    is_alu  = (alu != ALU_NOP);
    illegal = !is_alu && (flow == FLOW_NONE) && (mem == MEM_NONE);
    r_w     = is_alu;
    wr      = is_alu || (mem == MEM_LD) || (mem == MEM_POP) || (mem == MEM_LD_IMM);
    rtype   = is_alu || (mem == MEM_LD) || (mem == MEM_LD_IMM);
    use_s1  = !illegal && (flow != FLOW_JMP) && (mem != MEM_POP) && (mem != MEM_LD_IMM);
    use_s2  = (is_alu && !imm) || (flow == FLOW_BEQ) || (mem == MEM_ST) || (mem == MEM_PUSH);
    s1      = in_inst[S1_LSB +: REG_ADDR_W];
    s2      = in_inst[S2_LSB +: REG_ADDR_W];
    dest    = rtype ? in_inst[DEST_LSB +: REG_ADDR_W] : s2;
  end

  logic                  out_valid_q, out_valid_d;
  logic [7:0]            out_alu_mode_q, out_alu_mode_d;
  logic                  out_r_w_q, out_r_w_d;
  logic                  out_wr_q, out_wr_d;
  logic [2:0]            out_mem_mode_q, out_mem_mode_d;
  logic [2:0]            out_flow_mode_q, out_flow_mode_d;
  logic [REG_ADDR_W-1:0] out_reg_s1_q, out_reg_s1_d;
  logic [REG_ADDR_W-1:0] out_reg_s2_q, out_reg_s2_d;
  logic [REG_ADDR_W-1:0] out_reg_dest_q, out_reg_dest_d;
  logic [MEM_ADDR_W-1:0] out_address_q, out_address_d;
  logic                  out_illegal_q, out_illegal_d;
  logic [CNT_W-1:0]      cnt_issued_q, cnt_issued_d;
  logic [CNT_W-1:0]      cnt_illegal_q, cnt_illegal_d;
  logic                  trap_q, trap_d;

  logic                  busy_s1, busy_s2;
  logic [NUM_REGS-1:0]   busy_vec;
  logic                  issue, accept, hazard;
  logic                  held_s1, held_s2, held_dest;

  assign issue = out_valid_q && out_ready && !flush;

  dsp_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue && out_wr_q),
    .set_reg   (out_reg_dest_q),
    .clr_en    (wb_valid),
    .clr_reg   (wb_reg),
    .rd_a_reg  (s1),
    .rd_a_busy (busy_s1),
    .rd_b_reg  (s2),
    .rd_b_busy (busy_s2),
    .busy      (busy_vec)
  );

  // The held op has not reached the scoreboard yet, so compare against its dest directly.
  always_comb begin
    held_s1   = out_valid_q && out_wr_q && (out_reg_dest_q == s1);
    held_s2   = out_valid_q && out_wr_q && (out_reg_dest_q == s2);
    held_dest = out_valid_q && out_wr_q && (out_reg_dest_q == dest);
    hazard    = (use_s1 && (busy_s1 || held_s1)) ||
                (use_s2 && (busy_s2 || held_s2)) ||
                (wr && (busy_vec[dest] || held_dest));
    in_ready  = !rst && !flush && !hazard && (!out_valid_q || out_ready);
`ifdef DSP_DECODE_TRAP_EN
    in_ready  = in_ready && !trap_q;
`endif
    accept    = in_valid && in_ready;
  end

  always_comb begin
    out_valid_d     = out_valid_q;
    out_alu_mode_d  = out_alu_mode_q;
    out_r_w_d       = out_r_w_q;
    out_wr_d        = out_wr_q;
    out_mem_mode_d  = out_mem_mode_q;
    out_flow_mode_d = out_flow_mode_q;
    out_reg_s1_d    = out_reg_s1_q;
    out_reg_s2_d    = out_reg_s2_q;
    out_reg_dest_d  = out_reg_dest_q;
    out_address_d   = out_address_q;
    out_illegal_d   = out_illegal_q;
    cnt_issued_d    = cnt_issued_q;
    cnt_illegal_d   = cnt_illegal_q;
    trap_d          = trap_q;

    if (accept) begin
      out_valid_d     = TRUE;
      out_alu_mode_d  = alu;
      out_r_w_d       = r_w;
      out_wr_d        = wr;
      out_mem_mode_d  = mem;
      out_flow_mode_d = flow;
      out_reg_s1_d    = s1;
      out_reg_s2_d    = s2;
      out_reg_dest_d  = dest;
      out_address_d   = in_inst[MEM_ADDR_W-1:0];
      out_illegal_d   = illegal;
    end else if (flush || out_ready) begin
      out_valid_d = FALSE;
    end

    if (issue) begin
      if (cnt_issued_q != '1) cnt_issued_d = cnt_issued_q + CNT_W'(1);
      if (out_illegal_q && (cnt_illegal_q != '1)) cnt_illegal_d = cnt_illegal_q + CNT_W'(1);
    end

    if (flush)                       trap_d = FALSE;
    else if (issue && out_illegal_q) trap_d = TRUE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      out_alu_mode_q  <= '0;
      out_r_w_q       <= 1'b0;
      out_wr_q        <= 1'b0;
      out_mem_mode_q  <= '0;
      out_flow_mode_q <= '0;
      out_reg_s1_q    <= '0;
      out_reg_s2_q    <= '0;
      out_reg_dest_q  <= '0;
      out_address_q   <= '0;
      out_illegal_q   <= 1'b0;
      cnt_issued_q    <= '0;
      cnt_illegal_q   <= '0;
      trap_q          <= 1'b0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_alu_mode_q  <= out_alu_mode_d;
      out_r_w_q       <= out_r_w_d;
      out_wr_q        <= out_wr_d;
      out_mem_mode_q  <= out_mem_mode_d;
      out_flow_mode_q <= out_flow_mode_d;
      out_reg_s1_q    <= out_reg_s1_d;
      out_reg_s2_q    <= out_reg_s2_d;
      out_reg_dest_q  <= out_reg_dest_d;
      out_address_q   <= out_address_d;
      out_illegal_q   <= out_illegal_d;
      cnt_issued_q    <= cnt_issued_d;
      cnt_illegal_q   <= cnt_illegal_d;
      trap_q          <= trap_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_alu_mode  = out_alu_mode_q;
  assign out_r_w       = out_r_w_q;
  assign out_mem_mode  = out_mem_mode_q;
  assign out_flow_mode = out_flow_mode_q;
  assign out_reg_s1    = out_reg_s1_q;
  assign out_reg_s2    = out_reg_s2_q;
  assign out_reg_dest  = out_reg_dest_q;
  assign out_address   = out_address_q;
  assign out_illegal   = out_illegal_q;
  assign cnt_issued    = cnt_issued_q;
  assign cnt_illegal   = cnt_illegal_q;
`ifdef DSP_DECODE_TRAP_EN
  assign trap          = trap_q;
`else
  logic unused_trap;
  assign unused_trap   = trap_q;
`endif

endmodule

// File: tb/tb_dsp_decode_stage.sv
// Directed-vector bench for dsp_decode_stage; inputs change and outputs are sampled on the falling edge.
module tb_dsp_decode_stage;
  import dsp_decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst;
  logic [7:0]  out_alu_mode;
  logic        out_r_w, out_illegal, wb_valid;
  logic [2:0]  out_mem_mode, out_flow_mode;
  logic [4:0]  out_reg_s1, out_reg_s2, out_reg_dest, wb_reg;
  logic [15:0] out_address, cnt_issued, cnt_illegal;
`ifdef DSP_DECODE_TRAP_EN
  logic        trap;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dsp_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_mode(out_alu_mode), .out_r_w(out_r_w),
    .out_mem_mode(out_mem_mode), .out_flow_mode(out_flow_mode),
    .out_reg_s1(out_reg_s1), .out_reg_s2(out_reg_s2), .out_reg_dest(out_reg_dest),
    .out_address(out_address), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_reg(wb_reg),
    .cnt_issued(cnt_issued), .cnt_illegal(cnt_illegal)
`ifdef DSP_DECODE_TRAP_EN
    , .trap(trap)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [4:0] d);
    return {op, s1, s2, d, 11'd0};
  endfunction

  task automatic wb(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_reg   = r;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0022_1800; wb_valid = 1'b0; wb_reg = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_alu", 32'(out_alu_mode), 0);
    check("rst_dest", 32'(out_reg_dest), 0);
    check("rst_cnt_issued", 32'(cnt_issued), 0);
    check("rst_cnt_illegal", 32'(cnt_illegal), 0);

    // ADD r3 <- r1,r2 then SUB r4 <- r3,r1 back-to-back
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h0022_1800;
    #1 check("add_ready", 32'(in_ready), 1);
    @(negedge clk);
    check("add_valid", 32'(out_valid), 1);
    check("add_alu", 32'(out_alu_mode), 32'(ALU_ADD));
    check("add_dest", 32'(out_reg_dest), 3);
    check("add_s1", 32'(out_reg_s1), 1);
    check("add_s2", 32'(out_reg_s2), 2);
    check("add_r_w", 32'(out_r_w), 1);
    check("add_addr", 32'(out_address), 32'h1800);
    check("add_mem", 32'(out_mem_mode), 32'(MEM_NONE));
    in_inst = 32'h1061_2000;
    #1 check("sub_stall_held", 32'(in_ready), 0);
    @(negedge clk);
    check("add_cnt_issued", 32'(cnt_issued), 1);
    check("sub_not_taken", 32'(out_valid), 0);
    check("sub_stall_busy", 32'(in_ready), 0);
    wb_valid = 1'b1; wb_reg = 5'd3;
    #1 check("sub_stall_wb_edge", 32'(in_ready), 0);
    @(negedge clk);
    wb_valid = 1'b0;
    #1 check("sub_ready_after_wb", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("sub_valid", 32'(out_valid), 1);
    check("sub_alu", 32'(out_alu_mode), 32'(ALU_SUB));
    check("sub_dest", 32'(out_reg_dest), 4);
    check("sub_s1", 32'(out_reg_s1), 3);
    @(negedge clk);
    check("sub_cnt_issued", 32'(cnt_issued), 2);
    wb(5'd4);

    // Full throughput: 8 independent ADDs
    for (int i = 0; i < 8; i++) begin
      in_inst  = mk(OP_ADD, 5'(16 + i), 5'(24 + i), 5'(8 + i));
      in_valid = 1'b1;
      #1 check("thr_ready", 32'(in_ready), 1);
      if (i > 0) begin
        check("thr_valid", 32'(out_valid), 1);
        check("thr_dest", 32'(out_reg_dest), 32'(8 + i - 1));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("thr_last_dest", 32'(out_reg_dest), 15);
    @(negedge clk);
    check("thr_cnt_issued", 32'(cnt_issued), 10);
    for (int r = 8; r < 16; r++) wb(5'(r));

    // Backpressure: AND r17 held for 3 cycles, OR r18 waits
    out_ready = 1'b0; in_valid = 1'b1; in_inst = mk(OP_AND, 5'd1, 5'd2, 5'd17);
    #1 check("bp_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_inst = mk(OP_OR, 5'd3, 5'd4, 5'd18);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_valid", 32'(out_valid), 1);
      check("bp_dest", 32'(out_reg_dest), 17);
      check("bp_alu", 32'(out_alu_mode), 32'(ALU_AND));
      check("bp_in_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_dest", 32'(out_reg_dest), 18);
    check("bp_next_alu", 32'(out_alu_mode), 32'(ALU_OR));
    check("bp_issue_once", 32'(cnt_issued), 11);
    @(negedge clk);
    check("bp_cnt_after", 32'(cnt_issued), 12);
    @(negedge clk);
    check("bp_cnt_stable", 32'(cnt_issued), 12);
    wb(5'd17);
    wb(5'd18);

    // Illegal opcode 0x3F
    in_inst = 32'hFC00_0000; in_valid = 1'b1;
    #1 check("ill_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("ill_flag", 32'(out_illegal), 1);
    check("ill_valid", 32'(out_valid), 1);
    check("ill_alu", 32'(out_alu_mode), 32'(ALU_NOP));
    check("ill_r_w", 32'(out_r_w), 0);
    check("ill_flow", 32'(out_flow_mode), 32'(FLOW_NONE));
    @(negedge clk);
    check("ill_cnt_illegal", 32'(cnt_illegal), 1);
    check("ill_cnt_issued", 32'(cnt_issued), 13);
    in_inst = mk(OP_ADD, 5'd1, 5'd2, 5'd3);
`ifdef DSP_DECODE_TRAP_EN
    check("trap_set", 32'(trap), 1);
    #1 check("trap_blocks", 32'(in_ready), 0);
    @(negedge clk);
    check("trap_sticky", 32'(trap), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("trap_cleared", 32'(trap), 0);
    #1 check("trap_ready_again", 32'(in_ready), 1);
`else
    #1 check("ill_no_halt", 32'(in_ready), 1);
`endif

    // Flush while holding LD r5
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_inst = mk(OP_LD, 5'd1, 5'd0, 5'd5);
    #1 check("ld_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("ld_valid", 32'(out_valid), 1);
    check("ld_mem", 32'(out_mem_mode), 32'(MEM_LD));
    check("ld_r_w", 32'(out_r_w), 0);
    check("ld_dest", 32'(out_reg_dest), 5);
    flush = 1'b1; out_ready = 1'b1;
    #1 check("flush_ready", 32'(in_ready), 0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid", 32'(out_valid), 0);
    check("flush_no_issue", 32'(cnt_issued), 13);
    in_inst = mk(OP_ADD, 5'd5, 5'd5, 5'd6);
    #1 check("flush_r5_free", 32'(in_ready), 1);

    // Same-cycle writeback and issue on r7: set wins
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_inst = mk(OP_ADD, 5'd1, 5'd2, 5'd7);
    #1 check("r7_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b1; wb_reg = 5'd7;
    @(negedge clk);
    wb_valid = 1'b0;
    check("r7_cnt_issued", 32'(cnt_issued), 14);
    in_inst = mk(OP_ADD, 5'd7, 5'd1, 5'd9);
    #1 check("r7_raw_busy", 32'(in_ready), 0);
    in_inst = mk(OP_ADD, 5'd1, 5'd2, 5'd7);
    #1 check("r7_waw_busy", 32'(in_ready), 0);
    wb(5'd7);
    in_inst = mk(OP_ADD, 5'd7, 5'd1, 5'd9);
    #1 check("r7_free", 32'(in_ready), 1);

    // Register 0 is tracked
    in_inst = mk(OP_ADD_I, 5'd1, 5'd0, 5'd0); in_valid = 1'b1;
    #1 check("r0_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0; in_inst = mk(OP_SUB, 5'd0, 5'd1, 5'd2);
    #1 check("r0_held_hazard", 32'(in_ready), 0);
    @(negedge clk);
    #1 check("r0_busy_hazard", 32'(in_ready), 0);
    wb(5'd0);
    #1 check("r0_free", 32'(in_ready), 1);

    // BEQ: non-register-writing, dest from the s2 field
    in_inst = mk(OP_BEQ, 5'd1, 5'd2, 5'd9); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("beq_flow", 32'(out_flow_mode), 32'(FLOW_BEQ));
    check("beq_alu", 32'(out_alu_mode), 32'(ALU_NOP));
    check("beq_r_w", 32'(out_r_w), 0);
    check("beq_dest", 32'(out_reg_dest), 2);
    check("beq_illegal", 32'(out_illegal), 0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
